// File: rtl/ro_slot_scheduler_pkg.sv
// Shared sizing and slot-owner decode for the readout-line slot scheduler.
package ro_slot_scheduler_pkg;

    localparam int unsigned N_CH  = 8;
    localparam int unsigned CNT_W = 19;
    localparam int unsigned CH_W  = 3;

    // Count of consecutive ones from bit 0; the all-ones (idle) slot is decoded separately.
    function automatic logic [CH_W-1:0] trailing_ones(input logic [N_CH-1:0] b);
        logic [CH_W-1:0] k;
        logic            run;
        k   = '0;
        run = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (run && b[i]) begin
                k = k + CH_W'(1);
            end else begin
                run = 1'b0;
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/ro_slot_scheduler_capture.sv
// Per-channel event capture: 2-FF sync, rising-edge detect, pending/polarity latch, overflow flag.
module ro_slot_scheduler_capture (
    input  logic clk_master,
    input  logic rstb,
    input  logic in_eve,
    input  logic in_pol_eve,
    input  logic mask,
    input  logic serve,
    input  logic ovf_clr,
    output logic pending,
    output logic pol,
    output logic ovf
);

    logic eve_s1_q, eve_s2_q, eve_prev_q;
    logic pol_s1_q, pol_s2_q;
    logic pending_q, pending_d;
    logic pol_q, pol_d;
    logic ovf_q, ovf_d;
    logic rise, drop;

    always_comb begin
        rise      = eve_s2_q & ~eve_prev_q;
        drop      = mask & rise & pending_q & ~serve;
        pending_d = pending_q;
        pol_d     = pol_q;
        ovf_d     = ovf_q;
        if (!mask) begin
            pending_d = 1'b0;
        end else if (rise) begin
            // A rise on the serve edge replaces the served event; otherwise the first one is kept.
            pending_d = 1'b1;
            if (!drop) begin
                pol_d = pol_s2_q;
            end
        end else if (serve) begin
            pending_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            eve_s1_q   <= 1'b0;
            eve_s2_q   <= 1'b0;
            eve_prev_q <= 1'b0;
            pol_s1_q   <= 1'b0;
            pol_s2_q   <= 1'b0;
            pending_q  <= 1'b0;
            pol_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            eve_s1_q   <= in_eve;
            eve_s2_q   <= eve_s1_q;
            eve_prev_q <= eve_s2_q;
            pol_s1_q   <= in_pol_eve;
            pol_s2_q   <= pol_s1_q;
            pending_q  <= pending_d;
            pol_q      <= pol_d;
            ovf_q      <= ovf_d;
        end
    end

    assign pending = pending_q;
    assign pol     = pol_q;
    assign ovf     = ovf_q;

endmodule

// File: rtl/ro_slot_scheduler.sv
// Master gray counter and binary-weighted slot scheduler serialising channel events
// onto one readout pair with channel id and frame sync.
module ro_slot_scheduler
    import ro_slot_scheduler_pkg::*;
(
    input  logic             clk_master,
    input  logic             rstb,
    input  logic             en,
    input  logic [N_CH-1:0]  ch_mask,
    input  logic [N_CH-1:0]  in_eve,
    input  logic [N_CH-1:0]  in_pol_eve,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] gray,
    output logic [N_CH-1:0]  slot_grant,
    output logic             out_mux_eve,
    output logic             out_mux_pol_eve,
    output logic             out_valid,
    output logic [CH_W-1:0]  out_ch,
    output logic             frame_sync,
    output logic [N_CH-1:0]  ovf_sticky
);

    logic [CNT_W-1:0] bin_q, bin_d, bin_inc, gray_q, gray_d;
    logic [N_CH-1:0]  grant_q, grant_d, serve_vec, pending, pol;
    logic [CH_W-1:0]  ch_q, ch_d, owner;
    logic             valid_q, valid_d, mpol_q, mpol_d, fs_q, fs_d;
    logic             idle, served_eve;

    always_comb begin
        bin_inc    = bin_q + CNT_W'(1);
        owner      = trailing_ones(bin_q[N_CH-1:0]);
        idle       = &bin_q[N_CH-1:0];
        served_eve = pending[owner] & ch_mask[owner];
        serve_vec  = '0;
        if (en && !idle) begin
            serve_vec[owner] = 1'b1;
        end

        bin_d   = bin_q;
        gray_d  = gray_q;
        grant_d = '0;
        ch_d    = ch_q;
        valid_d = 1'b0;
        mpol_d  = 1'b0;
        fs_d    = 1'b0;
        if (en) begin
            bin_d  = bin_inc;
            gray_d = bin_inc ^ (bin_inc >> 1);
            if (idle) begin
                ch_d = '0;
                fs_d = 1'b1;
            end else begin
                grant_d = serve_vec;
                ch_d    = owner;
                valid_d = served_eve;
                mpol_d  = served_eve & pol[owner];
            end
        end
    end

    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            bin_q   <= '0;
            gray_q  <= '0;
            grant_q <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            mpol_q  <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            grant_q <= grant_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            mpol_q  <= mpol_d;
            fs_q    <= fs_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ro_slot_scheduler_capture u_capture (
            .clk_master (clk_master),
            .rstb       (rstb),
            .in_eve     (in_eve[i]),
            .in_pol_eve (in_pol_eve[i]),
            .mask       (ch_mask[i]),
            .serve      (serve_vec[i]),
            .ovf_clr    (ovf_clr),
            .pending    (pending[i]),
            .pol        (pol[i]),
            .ovf        (ovf_sticky[i])
        );
    end

    assign gray            = gray_q;
    assign slot_grant      = grant_q;
    assign out_ch          = ch_q;
    assign out_valid       = valid_q;
    assign out_mux_eve     = valid_q;
    assign out_mux_pol_eve = mpol_q;
    assign frame_sync      = fs_q;

endmodule

// File: tb/tb_ro_slot_scheduler.sv
// Bench for ro_slot_scheduler: directed vector table, corner-case sequences and
// randomised traffic checked against a slot-arithmetic reference model.
module tb_ro_slot_scheduler;

    localparam int NC = 8;
    localparam int CW = 19;

    logic          clk_master = 1'b0;
    logic          rstb, en, ovf_clr;
    logic [NC-1:0] ch_mask, in_eve, in_pol_eve;
    logic [CW-1:0] gray;
    logic [NC-1:0] slot_grant, ovf_sticky;
    logic          out_mux_eve, out_mux_pol_eve, out_valid, frame_sync;
    logic [2:0]    out_ch;

    always #5 clk_master = ~clk_master;

    ro_slot_scheduler dut (
        .clk_master      (clk_master),
        .rstb            (rstb),
        .en              (en),
        .ch_mask         (ch_mask),
        .in_eve          (in_eve),
        .in_pol_eve      (in_pol_eve),
        .ovf_clr         (ovf_clr),
        .gray            (gray),
        .slot_grant      (slot_grant),
        .out_mux_eve     (out_mux_eve),
        .out_mux_pol_eve (out_mux_pol_eve),
        .out_valid       (out_valid),
        .out_ch          (out_ch),
        .frame_sync      (frame_sync),
        .ovf_sticky      (ovf_sticky)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: slot number arithmetic plus a record of what was sampled on past edges.
    int unsigned   m_bin;
    logic [CW-1:0] m_gray;
    logic [NC-1:0] m_grant, m_pend, m_pol, m_ovf;
    logic [2:0]    m_ch;
    logic          m_valid, m_pol_out, m_fs;
    logic [NC-1:0] e1, e2, e3, p1, p2;

    function automatic int owner_of(input int unsigned b);
        int s = int'(b % 256);
        int k = 0;
        if (s == 255) return -1;
        while (s % 2 == 1) begin
            s = s / 2;
            k++;
        end
        return k;
    endfunction

    task automatic model_reset();
        m_bin = 0; m_gray = '0; m_grant = '0; m_pend = '0; m_pol = '0; m_ovf = '0;
        m_ch = '0; m_valid = 1'b0; m_pol_out = 1'b0; m_fs = 1'b0;
        e1 = '0; e2 = '0; e3 = '0; p1 = '0; p2 = '0;
    endtask

    task automatic model_edge();
        logic [NC-1:0] rise;
        int            o;
        bit            serve, drop;
        if (!rstb) begin
            model_reset();
            return;
        end
        rise = e2 & ~e3;
        o    = owner_of(m_bin);
        if (en) begin
            if (o < 0) begin
                m_grant = '0; m_ch = '0; m_valid = 1'b0; m_pol_out = 1'b0; m_fs = 1'b1;
            end else begin
                m_grant   = NC'(1) << o;
                m_ch      = 3'(o);
                m_valid   = m_pend[o] & ch_mask[o];
                m_pol_out = m_valid & m_pol[o];
                m_fs      = 1'b0;
            end
            m_bin  = (m_bin + 1) & 32'h7FFFF;
            m_gray = CW'(m_bin ^ (m_bin >> 1));
        end else begin
            m_grant = '0; m_valid = 1'b0; m_pol_out = 1'b0; m_fs = 1'b0;
        end
        for (int i = 0; i < NC; i++) begin
            serve = en && (o == i);
            drop  = ch_mask[i] && rise[i] && m_pend[i] && !serve;
            if (drop) m_ovf[i] = 1'b1;
            else if (ovf_clr) m_ovf[i] = 1'b0;
            if (!ch_mask[i]) m_pend[i] = 1'b0;
            else if (rise[i]) begin
                m_pend[i] = 1'b1;
                if (!drop) m_pol[i] = p2[i];
            end else if (serve) m_pend[i] = 1'b0;
        end
        e3 = e2; e2 = e1; e1 = in_eve;
        p2 = p1; p1 = in_pol_eve;
    endtask

    task automatic step();
        @(posedge clk_master);
        model_edge();
        @(negedge clk_master);
        check("outputs", {gray, slot_grant, out_valid, out_mux_eve, out_mux_pol_eve, frame_sync,
                          ovf_sticky},
              {m_gray, m_grant, m_valid, m_valid, m_pol_out, m_fs, m_ovf});
        check("out_ch", out_ch, m_ch);
    endtask

    typedef struct {
        logic          en;
        logic [CW-1:0] gray;
        logic [2:0]    ch;
        logic [NC-1:0] grant;
    } vec_t;

    vec_t vt[10];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt[NC];
        int n_fs, n_idle, n_hit, first_idx, idx_gap, found;
        logic pol_a, pol_b;
        logic [CW-1:0] g_hold;

        vt[0] = '{1'b1, 19'd1,  3'd0, 8'h01};
        vt[1] = '{1'b1, 19'd3,  3'd1, 8'h02};
        vt[2] = '{1'b1, 19'd2,  3'd0, 8'h01};
        vt[3] = '{1'b1, 19'd6,  3'd2, 8'h04};
        vt[4] = '{1'b0, 19'd6,  3'd2, 8'h00};
        vt[5] = '{1'b0, 19'd6,  3'd2, 8'h00};
        vt[6] = '{1'b1, 19'd7,  3'd0, 8'h01};
        vt[7] = '{1'b1, 19'd5,  3'd1, 8'h02};
        vt[8] = '{1'b1, 19'd4,  3'd0, 8'h01};
        vt[9] = '{1'b1, 19'd12, 3'd3, 8'h08};

        rstb = 1'b1; en = 1'b0; ch_mask = 8'hFF; in_eve = '0; in_pol_eve = '0; ovf_clr = 1'b0;
        model_reset();
        #2 rstb = 1'b0;
        #1 check("reset_initial", {gray, slot_grant, out_valid, out_ch, frame_sync, ovf_sticky}, 0);
        @(negedge clk_master);
        step(); step();
        rstb = 1'b1;

        // Run into the frame with an event pending on ch7, then reset mid-frame.
        en = 1'b1;
        repeat (20) step();
        in_eve[7] = 1'b1; in_pol_eve[7] = 1'b1;
        repeat (4) step();
        rstb = 1'b0; in_eve = '0; in_pol_eve = '0;
        #1 check("reset_midframe", {gray, slot_grant, out_valid, out_mux_pol_eve, out_ch,
                                    frame_sync, ovf_sticky}, 0);
        model_reset();
        step(); step();
        rstb = 1'b1;

        for (int r = 0; r < 10; r++) begin
            en = vt[r].en;
            step();
            check($sformatf("vec%0d", r), {gray, out_ch, slot_grant, out_valid},
                  {vt[r].gray, vt[r].ch, vt[r].grant, 1'b0});
        end

        // One full frame of slot ownership.
        en = 1'b1;
        for (int i = 0; i < NC; i++) cnt[i] = 0;
        n_fs = 0; n_idle = 0;
        for (int j = 0; j < 256; j++) begin
            step();
            for (int i = 0; i < NC; i++) cnt[i] += int'(slot_grant[i]);
            n_fs   += int'(frame_sync);
            n_idle += int'(slot_grant == 8'h00);
        end
        check("sched_ch0", cnt[0], 128);
        check("sched_ch3", cnt[3], 16);
        check("sched_ch7", cnt[7], 1);
        check("sched_fs", n_fs, 1);
        check("sched_idle", n_idle, 1);

        // Single event on ch3 with polarity 1.
        in_eve[3] = 1'b1; in_pol_eve[3] = 1'b1;
        found = 0;
        for (int j = 0; j < 40 && found == 0; j++) begin
            step();
            if (out_valid) found = 1;
        end
        check("ev3_seen", found, 1);
        check("ev3_ch_pol", {out_ch, out_mux_pol_eve}, {3'd3, 1'b1});
        step();
        check("ev3_single", out_valid, 0);
        in_eve[3] = 1'b0; in_pol_eve[3] = 1'b0;

        // Overflow on ch7 within one frame, starting just after a frame boundary.
        found = 0;
        for (int j = 0; j < 300 && found == 0; j++) begin
            step();
            if (frame_sync) found = 1;
        end
        check("fs_found", found, 1);
        in_eve[7] = 1'b1; step(); step();
        in_eve[7] = 1'b0; step(); step();
        in_eve[7] = 1'b1; step(); step();
        in_eve[7] = 1'b0; step(); step();
        check("ovf7_set", ovf_sticky[7], 1);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        check("ovf7_clr", ovf_sticky[7], 0);
        in_eve[7] = 1'b1; ovf_clr = 1'b1;
        step(); step(); step();
        ovf_clr = 1'b0;
        check("ovf7_set_wins", ovf_sticky[7], 1);
        in_eve[7] = 1'b0;
        n_hit = 0;
        for (int j = 0; j < 256; j++) begin
            step();
            n_hit += int'(out_valid && out_ch == 3'd7);
        end
        check("ovf7_one_out", n_hit, 1);

        // Masked ch2 is never served and never overflows.
        ch_mask = 8'hFB;
        n_hit = 0;
        for (int j = 0; j < 256; j++) begin
            in_eve[2] = ((j % 6) < 3);
            step();
            n_hit += int'(out_valid && out_ch == 3'd2);
        end
        in_eve[2] = 1'b0;
        check("mask_ch2_out", n_hit, 0);
        check("mask_ch2_ovf", ovf_sticky[2], 0);

        // Second ch0 rise lands exactly on the edge that serves the first.
        if (m_bin % 2 != 0) step();
        in_eve[0] = 1'b1; in_pol_eve[0] = 1'b0; step();
        in_eve[0] = 1'b0; step();
        in_eve[0] = 1'b1; in_pol_eve[0] = 1'b1; step();
        n_hit = 0; first_idx = -1; idx_gap = -1; pol_a = 1'b0; pol_b = 1'b0;
        for (int j = 0; j < 8; j++) begin
            step();
            if (out_valid && out_ch == 3'd0) begin
                n_hit++;
                if (first_idx < 0) begin
                    first_idx = j; pol_a = out_mux_pol_eve;
                end else begin
                    idx_gap = j - first_idx; pol_b = out_mux_pol_eve;
                end
            end
        end
        in_eve[0] = 1'b0; in_pol_eve[0] = 1'b0;
        check("coll_count", n_hit, 2);
        check("coll_gap", idx_gap, 2);
        check("coll_pols", {pol_a, pol_b}, 2'b01);
        check("coll_ovf0", ovf_sticky[0], 0);

        // Enable low: gray frozen, no output; the event captured meanwhile is served after.
        ch_mask = 8'hFF;
        en = 1'b0;
        g_hold = m_gray;
        in_eve[1] = 1'b1; in_pol_eve[1] = 1'b1;
        n_hit = 0;
        for (int j = 0; j < 10; j++) begin
            step();
            n_hit += int'(out_valid);
        end
        check("en0_gray", gray, g_hold);
        check("en0_valid", n_hit, 0);
        en = 1'b1;
        found = 0;
        for (int j = 0; j < 6 && found == 0; j++) begin
            step();
            if (out_valid) found = 1;
        end
        check("en1_seen", found, 1);
        check("en1_ch_pol", {out_ch, out_mux_pol_eve}, {3'd1, 1'b1});
        in_eve[1] = 1'b0; in_pol_eve[1] = 1'b0;

        // Randomised traffic against the model.
        for (int j = 0; j < 3000; j++) begin
            en         = (($urandom % 8) != 0);
            in_eve     = in_eve ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            in_pol_eve = 8'($urandom);
            ovf_clr    = (($urandom % 16) == 0);
            if (($urandom % 200) == 0) ch_mask = (($urandom % 2) == 0) ? 8'hFF : 8'($urandom);
            rstb       = (($urandom % 700) != 0);
            step();
        end
        rstb = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
